cpu_csr_unit: RTL and testbench
===============================

Name: cpu_csr_unit

Overview:
Machine-mode CSR unit for the RV32 core, successor to the two-register CSR file. Performs CSRRW/CSRRS/CSRRC read-modify-write internally and holds the trap state (mstatus, mtvec, mepc, mcause, mtval, mscratch). Also holds the 64-bit mcycle/minstret counters and sequences trap entry and mret. Sits beside the register file; the decode/execute stage drives it, and the fetch stage consumes the trap_target and mepc_out redirect values.

Parameters:
HART_ID, 0, value returned by read-only mhartid (0xF14)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
COUNTERS_EN, 1, 1 = mcycle/minstret implemented; 0 = they read 0 and ignore writes

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
raddr  in  12  CSR read address
rdata  out  32  combinational read data of raddr
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
waddr  in  12  CSR write address
wsrc  in  32  rs1 or zimm operand
illegal  out  1  combinational: raddr unimplemented, or csr_op≠0 and waddr unimplemented or read-only
trap  in  1  one-cycle trap-entry pulse
trap_pc  in  32  PC of trapping instruction
trap_cause  in  32  mcause value; bit31 = interrupt
trap_val  in  32  mtval value
mret  in  1  one-cycle mret pulse
instret  in  1  one instruction retired this cycle
trap_target  out  32  combinational trap vector
mepc_out  out  32  current mepc
mie_out  out  1  mstatus.MIE

Behaviour:
- Address map:
  - mstatus 0x300
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mtval 0x343
  - mcycle 0xB00 / mcycleh 0xB80
  - minstret 0xB02 / minstreth 0xB82
  - mhartid 0xF14, read-only
- Any other address is unimplemented: reads return 0 and assert illegal.
- Reset values (async, on rst=1):
  - mstatus.MIE=0, MPIE=0
  - mtvec=MTVEC_RESET
  - all other registers 0
  - outputs follow combinationally from these values.
- mstatus field masks:
  - only bit3 (MIE) and bit7 (MPIE) are writable.
  - MPP[12:11] reads 2'b11.
  - all other bits read 0.
- mtvec field masks:
  - bits[31:2] = base; bit0 = mode (0 direct, 1 vectored).
  - bit1 is hardwired 0.
- mepc: bits[1:0] are hardwired 0.
- Write value, computed from old value Q = current contents of waddr:
  - write: Q_new = wsrc
  - set: Q_new = Q | wsrc
  - clear: Q_new = Q & ~wsrc
  - Q_new is then masked, and committed on the next rising edge.
- Write suppression: illegal=1 → no state change. This also covers waddr[11:10]=2'b11 (read-only space).
- Latency: a write is visible on rdata the cycle after the edge; the same-cycle read returns the old value.
- Trap entry (trap=1), on the edge:
  - mepc←trap_pc&~3
  - mcause←trap_cause
  - mtval←trap_val
  - MPIE←MIE, then MIE←0
- mret (mret=1), on the edge: MIE←MPIE, MPIE←1.
- Priority when events coincide: trap > mret > CSR write.
  - A CSR write in the same cycle as trap or mret is discarded entirely, including to unrelated registers.
  - The counter increment still occurs.
- trap_target:
  - If mode=1 and trap_cause[31]=1: {base,2'b00} + 4·trap_cause[30:0] (32-bit wrap).
  - Otherwise: {base,2'b00}.
- Counters (COUNTERS_EN=1):
  - mcycle is a 64-bit counter that increments every cycle.
  - minstret increments when instret=1.
  - Both wrap from 2^64−1 to 0.
  - CSR write to a low or high half replaces that half with Q_new. The counter does not increment that cycle; the other half is held.
- Reset mid-operation: asserting rst on any cycle immediately forces all registers to reset values; pending trap/mret/write is lost.

Test Plan:
- Reset: rst=1 → rdata(0x305)=MTVEC_RESET, rdata(0x300)=0x0000_1800, mie_out=0, mcycle=0; release → mcycle reads 1, 2, 3 on successive cycles.
- RMW ops:
  - write 0x340←0xF0F0_F0F0, then set 0x0F00_0000 → 0xFFF0_F0F0.
  - clear 0xFF00_0000 → 0x00F0_F0F0.
  - write 0x300←0xFFFF_FFFF → reads 0x0000_1888.
- Trap sequence: MIE=1; trap with trap_pc=0x0000_1237, cause=0x0000_000B → mepc=0x1234, mcause=0xB, mstatus MIE=0/MPIE=1; next mret → MIE=1, MPIE=1.
- Vectored target: mtvec←0x0000_8001; cause 0x8000_0007 → trap_target=0x0000_801C; cause 0x0000_0002 → 0x0000_8000.
- Illegal access:
  - write to 0xF14 or 0x7C0 → illegal=1, no state change.
  - rdata(0x7C0)=0.
  - rdata(0xF14)=HART_ID with illegal=0 when csr_op=0.
- Collisions and wrap:
  - trap coinciding with a write to 0x340 → mscratch unchanged.
  - write mcycle low=0xFFFF_FFFF, high=0 → after two further cycles, high=1, low=1 (carry into high half).
  - instret held high for 3 cycles → minstret=3.

Source files
------------

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR unit: CSRRW/S/C read-modify-write, trap entry/mret sequencing,
// and 64-bit mcycle/minstret counters for the RV32 core.
module cpu_csr_unit #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  input  logic [1:0]  csr_op,
  input  logic [11:0] waddr,
  input  logic [31:0] wsrc,
  output logic        illegal,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instret,
  output logic [31:0] trap_target,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [32:0] rd_lk, wr_lk;
  logic [31:0] q_new;
  logic        wr_en, csr_wr;

  // Returns {implemented, value}; counters read as zero when not built in.
  function automatic logic [32:0] csr_lookup(input logic [11:0] a);
    logic [63:0] cyc, ins;
    cyc = COUNTERS_EN ? mcycle_q : 64'd0;
    ins = COUNTERS_EN ? minstret_q : 64'd0;
    case (a)
      A_MSTATUS:   return {1'b1, 19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MTVEC:     return {1'b1, mtvec_q};
      A_MSCRATCH:  return {1'b1, mscratch_q};
      A_MEPC:      return {1'b1, mepc_q};
      A_MCAUSE:    return {1'b1, mcause_q};
      A_MTVAL:     return {1'b1, mtval_q};
      A_MCYCLE:    return {1'b1, cyc[31:0]};
      A_MCYCLEH:   return {1'b1, cyc[63:32]};
      A_MINSTRET:  return {1'b1, ins[31:0]};
      A_MINSTRETH: return {1'b1, ins[63:32]};
      A_MHARTID:   return {1'b1, HART_ID};
      default:     return 33'd0;
    endcase
  endfunction

  function automatic logic [31:0] csr_rmw(input logic [1:0] op, input logic [31:0] q,
                                          input logic [31:0] src);
    case (op)
      2'b01:   return src;
      2'b10:   return q | src;
      2'b11:   return q & ~src;
      default: return q;
    endcase
  endfunction

  always_comb begin
    rd_lk = csr_lookup(raddr);
    wr_lk = csr_lookup(waddr);
  end

  assign rdata   = rd_lk[31:0];
  assign illegal = !rd_lk[32] ||
                   ((csr_op != 2'b00) && (!wr_lk[32] || (waddr[11:10] == 2'b11)));
  assign q_new   = csr_rmw(csr_op, wr_lk[31:0], wsrc);
  assign wr_en   = (csr_op != 2'b00) && !illegal;
  // Trap and mret take the cycle; a coincident CSR write is dropped.
  assign csr_wr  = wr_en && !trap && !mret;

  assign mepc_out    = mepc_q;
  assign mie_out     = mie_q;
  assign trap_target = (mtvec_q[0] && trap_cause[31])
                       ? {mtvec_q[31:2], 2'b00} + {trap_cause[29:0], 2'b00}
                       : {mtvec_q[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      if (trap) begin
        mepc_q   <= trap_pc & MEPC_MASK;
        mcause_q <= trap_cause;
        mtval_q  <= trap_val;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_wr) begin
        case (waddr)
          A_MSTATUS: begin
            mie_q  <= q_new[3];
            mpie_q <= q_new[7];
          end
          A_MTVEC:    mtvec_q    <= q_new & MTVEC_MASK;
          A_MSCRATCH: mscratch_q <= q_new;
          A_MEPC:     mepc_q     <= q_new & MEPC_MASK;
          A_MCAUSE:   mcause_q   <= q_new;
          A_MTVAL:    mtval_q    <= q_new;
          default: ;
        endcase
      end
      if (COUNTERS_EN) begin
        if (csr_wr && waddr == A_MCYCLE)       mcycle_q[31:0]  <= q_new;
        else if (csr_wr && waddr == A_MCYCLEH) mcycle_q[63:32] <= q_new;
        else                                   mcycle_q        <= mcycle_q + 64'd1;
        if (csr_wr && waddr == A_MINSTRET)       minstret_q[31:0]  <= q_new;
        else if (csr_wr && waddr == A_MINSTRETH) minstret_q[63:32] <= q_new;
        else if (instret)                        minstret_q        <= minstret_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Directed bench for cpu_csr_unit: per-cycle comparison against a register-map
// model, plus hand-computed literal checks on key sequences.
module tb_cpu_csr_unit;
  localparam logic [31:0] HART = 32'd5;
  localparam logic [31:0] MTV  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] raddr = 12'h300;
  logic [31:0] rdata;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] waddr = 12'h300;
  logic [31:0] wsrc = 32'd0;
  logic        illegal;
  logic        trap = 1'b0;
  logic [31:0] trap_pc = 32'd0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_val = 32'd0;
  logic        mret = 1'b0;
  logic        instret = 1'b0;
  logic [31:0] trap_target;
  logic [31:0] mepc_out;
  logic        mie_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  cpu_csr_unit #(.HART_ID(HART), .MTVEC_RESET(MTV), .COUNTERS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .csr_op(csr_op),
    .waddr(waddr), .wsrc(wsrc), .illegal(illegal), .trap(trap), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_val(trap_val), .mret(mret), .instret(instret),
    .trap_target(trap_target), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model state: architectural values as software would see them.
  logic        m_mie = 1'b0, m_mpie = 1'b0;
  logic [31:0] m_mtvec = MTV, m_mscratch = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
  logic [63:0] m_cyc = 0, m_ins = 0;

  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7)};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB82: return {1'b1, m_ins[63:32]};
      12'hF14: return {1'b1, HART};
      default: return 33'd0;
    endcase
  endfunction

  function automatic logic m_illegal();
    logic [32:0] r, w;
    r = m_read(raddr);
    w = m_read(waddr);
    return !r[32] || (csr_op != 2'b00 && (!w[32] || waddr[11:10] == 2'b11));
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [32:0] w;
    logic [31:0] nv;
    bit cyc_w, ins_w;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mtvec = MTV; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    end else begin
      w = m_read(waddr);
      case (csr_op)
        2'b01: nv = wsrc;
        2'b10: nv = w[31:0] | wsrc;
        2'b11: nv = w[31:0] & ~wsrc;
        default: nv = w[31:0];
      endcase
      cyc_w = 0; ins_w = 0;
      if (trap) begin
        m_mepc = {trap_pc[31:2], 2'b00};
        m_mcause = trap_cause;
        m_mtval = trap_val;
        m_mpie = m_mie;
        m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end else if (csr_op != 2'b00 && !m_illegal()) begin
        case (waddr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec = {nv[31:2], 1'b0, nv[0]};
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = {nv[31:2], 2'b00};
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_w = 1; end
          12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cyc_w = 1; end
          12'hB02: begin m_ins = {m_ins[63:32], nv}; ins_w = 1; end
          12'hB82: begin m_ins = {nv, m_ins[31:0]}; ins_w = 1; end
          default: ;
        endcase
      end
      if (!cyc_w) m_cyc = m_cyc + 1;
      if (!ins_w && instret) m_ins = m_ins + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [32:0] r;
    logic [31:0] tgt;
    if (chk_en) begin
      r = m_read(raddr);
      tgt = m_mtvec & 32'hFFFF_FFFC;
      if (m_mtvec[0] && trap_cause[31]) tgt = tgt + 32'(trap_cause[30:0]) * 32'd4;
      check("cyc_rdata", rdata, r[31:0]);
      check("cyc_illegal", {31'd0, illegal}, {31'd0, m_illegal()});
      check("cyc_trap_target", trap_target, tgt);
      check("cyc_mepc_out", mepc_out, m_mepc);
      check("cyc_mie_out", {31'd0, mie_out}, {31'd0, m_mie});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] v);
    raddr = a; waddr = a; csr_op = o; wsrc = v;
    tick();
    csr_op = 2'b00; wsrc = 32'd0;
  endtask

  initial begin
    #2 rst = 1'b1;
    chk_en = 1'b1;
    tick();
    rd("rst_mtvec", 12'h305, MTV);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    check("rst_mie", {31'd0, mie_out}, 32'd0);
    rd("rst_mcycle", 12'hB00, 32'd0);
    rst = 1'b0;
    tick(); rd("mcycle_1", 12'hB00, 32'd1);
    tick(); rd("mcycle_2", 12'hB00, 32'd2);
    tick(); rd("mcycle_3", 12'hB00, 32'd3);

    op(2'b01, 12'h340, 32'hF0F0_F0F0); rd("scratch_wr", 12'h340, 32'hF0F0_F0F0);
    op(2'b10, 12'h340, 32'h0F00_0000); rd("scratch_set", 12'h340, 32'hFFF0_F0F0);
    raddr = 12'h340; waddr = 12'h340; csr_op = 2'b11; wsrc = 32'hFF00_0000;
    #1 check("same_cycle_old", rdata, 32'hFFF0_F0F0);
    tick();
    csr_op = 2'b00; wsrc = 32'd0;
    rd("scratch_clr", 12'h340, 32'h00F0_F0F0);
    op(2'b01, 12'h300, 32'hFFFF_FFFF); rd("mstatus_mask", 12'h300, 32'h0000_1888);
    op(2'b01, 12'h300, 32'h0000_0008); rd("mstatus_mie", 12'h300, 32'h0000_1808);

    raddr = 12'h340; waddr = 12'h340; csr_op = 2'b01; wsrc = 32'h1234_5678;
    trap = 1'b1; trap_pc = 32'h0000_1237; trap_cause = 32'h0000_000B; trap_val = 32'h0000_CAFE;
    tick();
    trap = 1'b0; csr_op = 2'b00; wsrc = 32'd0;
    check("trap_mepc_out", mepc_out, 32'h0000_1234);
    rd("trap_mcause", 12'h342, 32'h0000_000B);
    rd("trap_mtval", 12'h343, 32'h0000_CAFE);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_scratch_kept", 12'h340, 32'h00F0_F0F0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_mie", {31'd0, mie_out}, 32'd1);
    trap = 1'b1; mret = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'd3;
    tick();
    trap = 1'b0; mret = 1'b0; trap_cause = 32'd0;
    rd("trap_over_mret", 12'h300, 32'h0000_1880);
    rd("trap_over_mret_epc", 12'h341, 32'h0000_2000);
    op(2'b01, 12'h341, 32'h0000_5677); rd("mepc_mask", 12'h341, 32'h0000_5674);

    op(2'b01, 12'h305, 32'h0000_8003); rd("mtvec_mask", 12'h305, 32'h0000_8001);
    trap_cause = 32'h8000_0007;
    #1 check("vec_irq", trap_target, 32'h0000_801C);
    trap_cause = 32'h0000_0002;
    #1 check("vec_exc", trap_target, 32'h0000_8000);
    trap_cause = 32'd0;

    rd("unimpl_rdata", 12'h7C0, 32'd0);
    check("unimpl_illegal", {31'd0, illegal}, 32'd1);
    rd("hartid", 12'hF14, HART);
    check("hartid_legal", {31'd0, illegal}, 32'd0);
    waddr = 12'hF14; csr_op = 2'b01; wsrc = 32'hFFFF;
    #1 check("ro_illegal", {31'd0, illegal}, 32'd1);
    tick();
    csr_op = 2'b00;
    rd("ro_kept", 12'hF14, HART);
    raddr = 12'h340; waddr = 12'h7C0; csr_op = 2'b01; wsrc = 32'h1111_1111;
    #1 check("unimpl_wr_illegal", {31'd0, illegal}, 32'd1);
    tick();
    csr_op = 2'b00;
    rd("unimpl_wr_kept", 12'h340, 32'h00F0_F0F0);

    op(2'b01, 12'hB00, 32'hFFFF_FFFF);
    op(2'b01, 12'hB80, 32'd0);
    rd("cyc_wr_hi", 12'hB80, 32'd0);
    rd("cyc_wr_lo", 12'hB00, 32'hFFFF_FFFF);
    tick(); tick();
    rd("cyc_carry_hi", 12'hB80, 32'd1);
    rd("cyc_carry_lo", 12'hB00, 32'd1);

    instret = 1'b1;
    tick(); tick(); tick();
    instret = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3);
    rd("minstreth_0", 12'hB82, 32'd0);

    raddr = 12'h340;
    #3 rst = 1'b1;
    rd("async_rst_scratch", 12'h340, 32'd0);
    rd("async_rst_mtvec", 12'h305, MTV);
    check("async_rst_mepc", mepc_out, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd("post_rst_mcycle", 12'hB00, 32'd1);
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
